// File: rtl/mult_sched_pkg.sv
// Shared encodings and sizing helpers for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // Smallest w with 2**w >= value, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Unsigned shift-and-add multiplier; RDY pulses WIDTH cycles after START, P holds until next START.
module seq_shift_add_mult
  import mult_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               RDY
);

  localparam int unsigned CntW = clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               active_q;
  logic               rdy_q;

  // Iteration 0 is folded into the load so RDY lands exactly WIDTH cycles after START.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (START) begin
        mcand_q  <= {{WIDTH{1'b0}}, A} << 1;
        acc_q    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
        mplier_q <= B >> 1;
        cnt_q    <= CntW'(1);
        active_q <= 1'b1;
      end else if (active_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          active_q <= 1'b0;
          rdy_q    <= 1'b1;
        end
      end
    end
  end

  assign P   = acc_q;
  assign RDY = rdy_q;

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin front end sharing one sequential multiplier among NREQ requesters.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] OPA,
  input  logic [NREQ*WIDTH-1:0] OPB,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [2*WIDTH-1:0]    PROD,
  output logic                  BUSY
);

  localparam int unsigned IdxW = clog2(NREQ);

  logic [1:0]         state_q, state_d;
  // The RR pointer is always the last winner, so it doubles as the owner of the in-flight op.
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  int unsigned        scan_idx;
  logic               mult_start;
  logic [WIDTH-1:0]   opa_win;
  logic [WIDTH-1:0]   opb_win;
  logic [2*WIDTH-1:0] mult_p;
  logic               mult_rdy;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NREQ;
      if (!win_found && REQ[IdxW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(scan_idx);
      end
    end
  end

  // Only the winner's slice reaches the datapath, so other requesters' operands are don't-care.
  assign mult_start = (state_q == StIdle) && win_found;
  assign opa_win    = OPA[32'(win_idx) * WIDTH +: WIDTH];
  assign opb_win    = OPB[32'(win_idx) * WIDTH +: WIDTH];

  seq_shift_add_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .START  (mult_start),
    .A      (opa_win),
    .B      (opb_win),
    .P      (mult_p),
    .RDY    (mult_rdy)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = '0;
    prod_d  = prod_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d   = NREQ'(1) << win_idx;
          ptr_d   = win_idx;
          state_d = StRun;
        end
      end
      StRun: begin
        if (mult_rdy) state_d = StResp;
      end
      StResp: begin
        prod_d  = mult_p;
        done_d  = NREQ'(1) << ptr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign PROD = prod_q;
  // The DONE cycle is already back in IDLE; keep BUSY up so it spans GNT through DONE.
  assign BUSY = (state_q != StIdle) || (done_q != '0);

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: vector table, held-request sequences, scoreboard.
module tb_mult_scheduler;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           CLK;
  logic           RESET_N;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] OPA;
  logic [N*W-1:0] OPB;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [2*W-1:0] PROD;
  logic           BUSY;

  mult_scheduler #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .REQ    (REQ),
    .OPA    (OPA),
    .OPB    (OPB),
    .GNT    (GNT),
    .DONE   (DONE),
    .PROD   (PROD),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0]   done;
    logic [2*W-1:0] prod;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] gnt;
  } vec_t;

  exp_t         sb[$];
  int           gq[$];
  int           n_cmp    = 0;
  int           n_err    = 0;
  int           cyc      = 0;
  int           done_cnt = 0;
  logic [W-1:0] opa_a[N];
  logic [W-1:0] opb_a[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      OPA[i*W +: W] = opa_a[i];
      OPB[i*W +: W] = opb_a[i];
    end
  endtask

  task automatic push_exp(input int w);
    exp_t           e;
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea      = {{W{1'b0}}, opa_a[w]};
    eb      = {{W{1'b0}}, opb_a[w]};
    e.done  = '0;
    e.done[w] = 1'b1;
    e.prod  = ea * eb;
    sb.push_back(e);
  endtask

  // Advance one cycle and check outputs at the falling edge.
  task automatic step();
    exp_t e;
    int   g;
    @(negedge CLK);
    cyc++;
    if (GNT != '0) begin
      gq.push_back(cyc);
      check("gnt_onehot", 32'($countones(GNT)), 32'd1);
      check("busy_at_gnt", 32'(BUSY), 32'd1);
    end
    if (DONE != '0) begin
      done_cnt++;
      check("done_onehot", 32'($countones(DONE)), 32'd1);
      check("gnt_done_disjoint", 32'(GNT), 32'd0);
      check("busy_at_done", 32'(BUSY), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(DONE), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_owner", 32'(DONE), 32'(e.done));
        check("prod", 32'(PROD), 32'(e.prod));
        if (gq.size() == 0) begin
          check("done_without_gnt", 32'(gq.size()), 32'd1);
        end else begin
          g = gq.pop_front();
          check("latency", 32'(cyc - g), 32'(W + 1));
        end
      end
    end
  endtask

  task automatic wait_gnt(input logic [N-1:0] exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (GNT == '0 && n < 40);
    check("gnt", 32'(GNT), 32'(exp));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      step();
      t++;
      if (sb.size() != 0) check("busy_in_op", 32'(BUSY), 32'd1);
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // seq holds expected winner indices, one per nibble, in grant order.
  task automatic run_held(input logic [N-1:0] req_v, input int n, input logic [31:0] seq);
    int         k;
    int         prev;
    int         t;
    logic [3:0] ix;
    k    = 0;
    prev = 0;
    t    = 0;
    for (int j = 0; j < n; j++) begin
      ix = seq[4*j +: 4];
      push_exp(int'(ix));
    end
    REQ = req_v;
    while (k < n && t < n * 15 + 20) begin
      step();
      t++;
      if (GNT != '0) begin
        ix = seq[4*k +: 4];
        check("held_gnt", 32'(GNT), 32'(1) << ix);
        if (k > 0) check("gnt_spacing", 32'(cyc - prev), 32'(W + 2));
        prev = cyc;
        k++;
        if (k == n) REQ = '0;
      end
    end
    check("held_count", 32'(k), 32'(n));
    REQ = '0;
    drain();
  endtask

  initial begin
    vec_t vecs[7];
    int   g0;
    int   d0;

    vecs[0] = '{4'b0001, 0, 8'd13,  8'd11,  4'b0001};
    vecs[1] = '{4'b0100, 2, 8'd255, 8'd255, 4'b0100};
    vecs[2] = '{4'b0100, 2, 8'd0,   8'd200, 4'b0100};
    vecs[3] = '{4'b1000, 3, 8'd200, 8'd3,   4'b1000};
    vecs[4] = '{4'b0010, 1, 8'd128, 8'd255, 4'b0010};
    vecs[5] = '{4'b0001, 0, 8'd77,  8'd0,   4'b0001};
    vecs[6] = '{4'b0100, 2, 8'd17,  8'd15,  4'b0100};

    RESET_N = 1'b0;
    REQ     = '0;
    for (int i = 0; i < N; i++) begin
      opa_a[i] = '0;
      opb_a[i] = '0;
    end
    drive_ops();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    step();
    check("reset_gnt", 32'(GNT), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_prod", 32'(PROD), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);

    // All four requesting from reset: requester 0 first, then rotate with wrap.
    for (int i = 0; i < N; i++) begin
      opa_a[i] = W'(i + 1);
      opb_a[i] = W'(i + 3);
    end
    drive_ops();
    run_held(4'b1111, 5, 32'h0000_3210);

    // Single-requester vectors; other requesters' operands are X.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) begin
        opa_a[i] = 'x;
        opb_a[i] = 'x;
      end
      opa_a[vecs[v].idx] = vecs[v].a;
      opb_a[vecs[v].idx] = vecs[v].b;
      drive_ops();
      push_exp(vecs[v].idx);
      REQ = vecs[v].req;
      wait_gnt(vecs[v].gnt);
      REQ = '0;
      for (int i = 0; i < N; i++) begin
        opa_a[i] = 'x;
        opb_a[i] = 'x;
      end
      drive_ops();
      drain();
      if (v == 0) begin
        step();
        check("busy_after_done", 32'(BUSY), 32'd0);
        check("done_after_done", 32'(DONE), 32'd0);
      end
    end

    // Pointer is at 2: REQ=0101 must wrap to 0, then serve 2.
    for (int i = 0; i < N; i++) begin
      opa_a[i] = 8'd6;
      opb_a[i] = 8'd7;
    end
    opa_a[2] = 8'd250;
    opb_a[2] = 8'd4;
    drive_ops();
    run_held(4'b0101, 2, 32'h0000_0020);

    // Request raised during RUN waits for the cycle after DONE.
    opa_a[0] = 8'd9;
    opb_a[0] = 8'd9;
    opa_a[3] = 8'd21;
    opb_a[3] = 8'd12;
    drive_ops();
    push_exp(0);
    push_exp(3);
    REQ = 4'b0001;
    wait_gnt(4'b0001);
    g0  = cyc;
    REQ = '0;
    repeat (3) step();
    REQ = 4'b1000;
    wait_gnt(4'b1000);
    check("gnt_after_busy", 32'(cyc - g0), 32'(W + 2));
    REQ = '0;
    drain();

    // Reset in the middle of a 7*9 operation.
    opa_a[1] = 8'd7;
    opb_a[1] = 8'd9;
    drive_ops();
    REQ = 4'b0010;
    wait_gnt(4'b0010);
    REQ = '0;
    repeat (3) step();
    RESET_N = 1'b0;
    #1;
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_prod", 32'(PROD), 32'd0);
    gq.delete();
    step();
    RESET_N = 1'b1;
    d0 = done_cnt;
    repeat (15) step();
    check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
    opa_a[1] = 8'd5;
    opb_a[1] = 8'd6;
    opa_a[2] = 8'd3;
    opb_a[2] = 8'd3;
    drive_ops();
    push_exp(1);
    REQ = 4'b0110;
    wait_gnt(4'b0010);
    REQ = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
